// File: rtl/pwm_capture.sv
// Measures period and high time of one asynchronous PWM line and reports the duty cycle on a 0..255 scale.
// A line with no rising edge for TIMEOUT cycles is flagged stuck and reported as 0 or 255.
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [7:0]       duty,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             duty_valid,
  output logic             locked,
  output logic             stuck
);
  localparam int NW = CNT_W + 8;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SYNC, MEASURE, DIVIDE} state_t;
  state_t state, state_nxt;

  logic             s_m, s, s_d;
  logic             rise, tgl, timeout, div_last, div_done, fit;
  logic [CNT_W-1:0] per_cnt, hi_cnt, per_l, hi_l;
  logic [NW-1:0]    num, trial;
  logic [7:0]       quo, quo_nxt;
  logic [3:0]       step;
  logic [2:0]       bit_idx;

  // Synchronizer keeps running while disabled so re-enable never sees a stale edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      s_m <= 1'b0;
      s   <= 1'b0;
      s_d <= 1'b0;
    end else begin
      s_m <= pwm_in;
      s   <= s_m;
      s_d <= s;
    end
  end

  assign rise     = s & ~s_d;
  assign tgl      = s ^ s_d;
  assign timeout  = (per_cnt == TMO) && ((state == MEASURE) || ((state == SYNC) && !stuck));
  assign div_last = (state == DIVIDE) && (step == 4'd7);
  assign div_done = (state == DIVIDE) && (step == 4'd8);
  assign bit_idx  = 3'd7 - step[2:0];
  assign trial    = {8'd0, per_l} << bit_idx;
  assign fit      = (num >= trial);

  always_comb begin
    quo_nxt = quo;
    if (fit) quo_nxt[bit_idx] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset || !enable) state <= IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = SYNC;
      SYNC:    if (!timeout && rise) state_nxt = MEASURE;
      MEASURE: if (timeout) state_nxt = SYNC;
               else if (rise) state_nxt = DIVIDE;
      DIVIDE:  if (div_done) state_nxt = MEASURE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= CNT_W'(1);
      hi_cnt  <= CNT_W'(1);
    end else begin
      if (per_cnt != TMO) per_cnt <= per_cnt + CNT_W'(1);
      if (s && (hi_cnt != '1)) hi_cnt <= hi_cnt + CNT_W'(1);
    end
  end

  // Restoring divider: high*255 / period, one quotient bit per cycle, MSB first.
  // Step 8 is a dead cycle so a rise right after the report is still discarded.
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      per_l <= '0;
      hi_l  <= '0;
      num   <= '0;
      quo   <= '0;
      step  <= '0;
    end else if ((state == MEASURE) && rise && !timeout) begin
      per_l <= per_cnt;
      hi_l  <= hi_cnt;
      num   <= ({8'd0, hi_cnt} << 8) - {8'd0, hi_cnt};
      quo   <= '0;
      step  <= '0;
    end else if (state == DIVIDE) begin
      step <= step + 4'd1;
      if (!step[3] && fit) begin
        num <= num - trial;
        quo <= quo_nxt;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      duty       <= '0;
      period     <= '0;
      high_time  <= '0;
      duty_valid <= 1'b0;
      locked     <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (div_last) begin
        duty       <= quo_nxt;
        period     <= per_l;
        high_time  <= hi_l;
        duty_valid <= 1'b1;
        locked     <= 1'b1;
        stuck      <= 1'b0;
      end else if (timeout) begin
        duty       <= {8{s}};
        period     <= '0;
        high_time  <= '0;
        duty_valid <= 1'b1;
        locked     <= 1'b0;
        stuck      <= 1'b1;
      end else if (stuck && tgl) begin
        duty       <= {8{s}};
        duty_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: a behavioural model predicts every duty_valid report into a queue,
// a monitor pops and compares on each pulse; directed steps check spec values at phase ends.
module tb_pwm_capture;
  localparam int CNT_W = 16;
  localparam int TMO   = 1024;

  typedef struct packed {
    logic [7:0]  duty;
    logic [15:0] per;
    logic [15:0] hi;
    logic        lk;
    logic        st;
  } rec_t;

  logic        clock = 1'b0;
  logic        reset, enable, pwm_in;
  logic [7:0]  duty;
  logic [15:0] period, high_time;
  logic        duty_valid, locked, stuck;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .enable(enable), .pwm_in(pwm_in),
    .duty(duty), .period(period), .high_time(high_time),
    .duty_valid(duty_valid), .locked(locked), .stuck(stuck)
  );

  always #5 clock = ~clock;

  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, n_pulse = 0, div_pulses = 0, last_pulse_cyc = 0, last_rise = 0;
  bit   mon_on = 0, stuck_seen = 0;
  rec_t q[$];
  rec_t last_r, exp_r, got_r, r;

  // model state
  bit   ms1, ms, msd, rs, tg, to;
  int   mper, mhi, mst, mcd, mperl, mhil;
  bit   mstuck;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pwm_run(input int per, input int hi, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock); pwm_in = 1'b1; last_rise = cyc;
      repeat (hi - 1) @(negedge clock);
      @(negedge clock); pwm_in = 1'b0;
      repeat (per - hi - 1) @(negedge clock);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 64'({duty, period, high_time, duty_valid, locked, stuck}), 64'd0);
  endtask

  initial begin
    int  p0;
    bit  found;
    reset = 1'b1; enable = 1'b1; pwm_in = 1'b0;
    ms1 = 0; ms = 0; msd = 0; mper = 0; mhi = 0; mst = 0; mcd = 0; mperl = 1; mhil = 0; mstuck = 0;

    fork
      // behavioural model: pushes the record expected on the report cycle
      forever begin
        @(posedge clock);
        cyc++;
        rs = ms && !msd;
        tg = ms != msd;
        if (reset || !enable) begin
          mst = 0; mper = 0; mhi = 0; mcd = 0; mstuck = 0;
        end else begin
          to = (mper == TMO) && (mst == 2 || (mst == 1 && !mstuck));
          if (mst == 3 && mcd == 8) begin
            r.duty = 8'((mhil * 255) / mperl); r.per = 16'(mperl); r.hi = 16'(mhil);
            r.lk = 1'b1; r.st = 1'b0; mstuck = 0; q.push_back(r);
          end else if (to) begin
            r.duty = ms ? 8'hff : 8'h00; r.per = 0; r.hi = 0; r.lk = 0; r.st = 1;
            mstuck = 1; q.push_back(r);
          end else if (mstuck && tg) begin
            r.duty = ms ? 8'hff : 8'h00; r.per = 0; r.hi = 0; r.lk = 0; r.st = 1;
            q.push_back(r);
          end
          case (mst)
            0: mst = 1;
            1: if (!to && rs) mst = 2;
            2: if (to) mst = 1;
               else if (rs) begin mperl = mper; mhil = mhi; mst = 3; mcd = 1; end
            default: if (mcd == 9) mst = 2; else mcd++;
          endcase
          if (rs) begin mper = 1; mhi = 1; end
          else begin
            if (mper < TMO) mper++;
            if (ms && mhi < 65535) mhi++;
          end
        end
        if (reset) begin ms1 = 0; ms = 0; msd = 0; end
        else begin msd = ms; ms = ms1; ms1 = pwm_in; end
      end
      // monitor: every pulse must match the next predicted record
      forever begin
        @(negedge clock);
        if (mon_on) begin
          chk("no_x", 64'($isunknown({duty, period, high_time, duty_valid, locked, stuck})), 64'd0);
          if (stuck === 1'b1) stuck_seen = 1;
          if (duty_valid === 1'b1 || q.size() != 0) begin
            chk("pulse_timing", 64'(duty_valid), 64'(q.size() != 0));
            if (duty_valid === 1'b1) begin
              n_pulse++; last_pulse_cyc = cyc;
              got_r = {duty, period, high_time, locked, stuck};
              last_r = got_r;
              if (stuck !== 1'b1) div_pulses++;
              if (q.size() != 0) begin
                exp_r = q.pop_front();
                chk("pulse_rec", 64'(got_r), 64'(exp_r));
              end
            end else q.delete();
          end
        end
      end
    join_none

    // 1: reset priority over enable, then first lock at 256/128
    @(negedge clock); mon_on = 1;
    for (int i = 0; i < 3; i++) begin
      chk_zero("reset_outputs");
      pwm_in = ~pwm_in;
      @(negedge clock);
    end
    reset = 1'b0; pwm_in = 1'b0;
    p0 = n_pulse;
    pwm_run(256, 128, 1);
    chk("p1_no_pulse_first_rise", 64'(n_pulse - p0), 64'd0);
    pwm_run(256, 128, 1);
    chk("p1_pulse_cnt", 64'(n_pulse - p0), 64'd1);
    chk("p1_latency", 64'(last_pulse_cyc - last_rise), 64'd11);
    chk("p1_rec", 64'(last_r), 64'({8'd127, 16'd256, 16'd128, 1'b1, 1'b0}));
    pwm_run(256, 128, 2);
    chk("p1_locked", 64'(locked), 64'd1);

    // 2: duty 63 then 254, one pulse per period
    p0 = n_pulse;
    pwm_run(256, 64, 3);
    chk("p2_pulse_cnt", 64'(n_pulse - p0), 64'd3);
    chk("p2_rec64", 64'(last_r), 64'({8'd63, 16'd256, 16'd64, 1'b1, 1'b0}));
    pwm_run(256, 255, 3);
    chk("p2_rec255", 64'(last_r), 64'({8'd254, 16'd256, 16'd255, 1'b1, 1'b0}));

    // 3: stuck high, stuck low, recovery
    p0 = n_pulse;
    @(negedge clock); pwm_in = 1'b1;
    repeat (TMO + 30) @(negedge clock);
    chk("p3_hold_pulses", 64'(n_pulse - p0), 64'd2);
    chk("p3_stuck_hi", 64'(last_r), 64'({8'd255, 16'd0, 16'd0, 1'b0, 1'b1}));
    chk("p3_stuck_flags", 64'({stuck, locked}), 64'b10);
    p0 = n_pulse;
    pwm_in = 1'b0;
    repeat (10) @(negedge clock);
    chk("p3_low_pulses", 64'(n_pulse - p0), 64'd1);
    chk("p3_stuck_lo", 64'(last_r), 64'({8'd0, 16'd0, 16'd0, 1'b0, 1'b1}));
    pwm_run(100, 25, 4);
    chk("p3_recover", 64'(last_r), 64'({8'd63, 16'd100, 16'd25, 1'b1, 1'b0}));

    // 4: period 8, every other rise lands in DIVIDE
    p0 = n_pulse;
    pwm_run(8, 4, 12);
    chk("p4_pulse_cnt", 64'(n_pulse - p0), 64'd6);
    chk("p4_rec", 64'(last_r), 64'({8'd127, 16'd8, 16'd4, 1'b1, 1'b0}));

    // 5: disable mid-DIVIDE, re-enable needs two rises
    pwm_run(256, 128, 2);
    @(negedge clock); pwm_in = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (mst == 3 && mcd == 3) found = 1;
    end
    chk("p5_reach_divide", 64'(found), 64'd1);
    enable = 1'b0;
    @(negedge clock);
    chk_zero("p5_disable_now");
    repeat (5) @(negedge clock);
    chk_zero("p5_disable_hold");
    pwm_in = 1'b0;
    repeat (5) @(negedge clock);
    enable = 1'b1;
    p0 = n_pulse;
    pwm_run(100, 50, 1);
    chk("p5_first_rise_silent", 64'(n_pulse - p0), 64'd0);
    pwm_run(100, 50, 2);
    chk("p5_pulse_cnt", 64'(n_pulse - p0), 64'd2);
    chk("p5_rec", 64'(last_r), 64'({8'd127, 16'd100, 16'd50, 1'b1, 1'b0}));

    // 6: just under and just over the timeout
    stuck_seen = 0;
    pwm_run(1023, 512, 3);
    chk("p6_no_stuck", 64'(stuck_seen), 64'd0);
    chk("p6_rec1023", 64'(last_r), 64'({8'd127, 16'd1023, 16'd512, 1'b1, 1'b0}));
    pwm_run(1025, 512, 1);
    div_pulses = 0;
    pwm_run(1025, 512, 3);
    chk("p6_no_div_pulse", 64'(div_pulses), 64'd0);
    chk("p6_stuck", 64'({stuck, locked}), 64'b10);

    repeat (4) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
